// File: rtl/common.sv
// rtl/common.sv - shared multicycle op encoding, latencies and helpers
package common;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } multicycle_t;

  localparam int MUL_LATENCY = 3;
  localparam int DIV_LATENCY = 34;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is correct unsigned.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - restoring radix-2 divider, one step per enable on 32-bit magnitudes
module div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] trial;

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    // Borrow out of bit 32 means the shifted remainder was below the divisor.
    trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (en) begin
      if (!trial[32]) begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = {rem_q[30:0], quo_q[31]};
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == 6'd31);

endmodule

// File: rtl/multdiv_engine.sv
// rtl/multdiv_engine.sv - multicycle MULT/MULTU/DIV/DIVU engine with hi/lo result registers
module multdiv_engine
  import common::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  multicycle_t op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        ok
);

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, DIV, FIX, DONE} state_t;

  state_t            state_q, state_d;
  multicycle_t       op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [3:0][31:0]  pp_q, pp_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;

  logic        sgn_in, sgn_q, neg_res;
  logic [31:0] am, bm;
  logic [63:0] product, product_s;
  logic [31:0] quo, rem;
  logic        div_last;

  assign sgn_in  = (op == OP_MULT) || (op == OP_DIV);
  assign sgn_q   = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign am      = mag(a_q, sgn_q);
  assign bm      = mag(b_q, sgn_q);
  assign neg_res = sgn_q && (a_q[31] ^ b_q[31]);
  assign product = {pp_q[3], 32'b0} + {16'b0, pp_q[1], 16'b0}
                 + {16'b0, pp_q[2], 16'b0} + {32'b0, pp_q[0]};
  assign product_s = neg_res ? -product : product;

  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (state_q == IDLE && start),
    .en        (state_q == DIV),
    .dividend  (mag(a, sgn_in)),
    .divisor   (mag(b, sgn_in)),
    .quotient  (quo),
    .remainder (rem),
    .last      (div_last)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    pp_d    = pp_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op;
        a_d     = a;
        b_d     = b;
        state_d = (op == OP_MULT || op == OP_MULTU) ? MUL1 : DIV;
      end
      MUL1: begin
        pp_d[0] = {16'b0, am[15:0]}  * {16'b0, bm[15:0]};
        pp_d[1] = {16'b0, am[15:0]}  * {16'b0, bm[31:16]};
        pp_d[2] = {16'b0, am[31:16]} * {16'b0, bm[15:0]};
        pp_d[3] = {16'b0, am[31:16]} * {16'b0, bm[31:16]};
        state_d = MUL2;
      end
      MUL2: begin
        {hi_d, lo_d} = product_s;
        state_d      = DONE;
      end
      DIV: if (div_last) state_d = FIX;
      FIX: begin
        // Divide by zero bypasses sign fix-up so the quotient is all ones either way.
        if (b_q == 32'd0) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = a_q;
        end else begin
          lo_d = neg_res ? -quo : quo;
          hi_d = (sgn_q && a_q[31]) ? -rem : rem;
        end
        state_d = DONE;
      end
      DONE: if (!stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      pp_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pp_q    <= pp_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
  assign ok = (state_q == DONE);

endmodule

// File: tb/tb_multdiv_engine.sv
// tb/tb_multdiv_engine.sv - scoreboard bench for multdiv_engine
module tb_multdiv_engine;
  import common::*;

  logic        clk = 1'b0;
  logic        reset, start, stall, flush;
  multicycle_t op;
  logic [31:0] a, b, hi, lo;
  logic        ok;

  multdiv_engine dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .stall (stall),
    .flush (flush),
    .hi    (hi),
    .lo    (lo),
    .ok    (ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          vectors = 0;
  int          fails = 0;
  logic        ok_prev = 1'b0;
  logic [31:0] last_hi = '0, last_lo = '0;
  int          ok_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising ok retires the oldest expected result.
  always @(negedge clk) begin
    if (ok === 1'b1 && ok_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL unexpected_ok: got hi=%h lo=%h expected no result", hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
    ok_prev = ok;
  end

  task automatic wait_ok();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ok !== 1'b1 && n < 100);
    if (ok !== 1'b1) begin
      vectors++;
      fails++;
      $display("FAIL ok_timeout: got ok=%b expected 1 within 100 cycles", ok);
    end
  endtask

  task automatic run_op(input multicycle_t o, input logic [31:0] ai, input logic [31:0] bi,
                        input logic [31:0] eh, input logic [31:0] el, input int lat,
                        input bit keep_start, input int stall_cycles);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = ai;
    b     = bi;
    e.hi = eh; e.lo = el; e.lat = lat; e.t0 = cyc;
    sb.push_back(e);
    wait_ok();
    ok_cyc = cyc;
    if (!keep_start) start = 1'b0;
    last_hi = eh;
    last_lo = el;
    if (stall_cycles > 0) begin
      stall = 1'b1;
      for (int i = 0; i < stall_cycles; i++) begin
        @(negedge clk);
        chk("stall_ok", 32'(ok), 32'd1);
        chk("stall_hi", hi, eh);
        chk("stall_lo", lo, el);
      end
      stall = 1'b0;
      @(negedge clk);
      chk("stall_release_ok", 32'(ok), 32'd0);
    end
  endtask

  initial begin
    int first_ok;
    reset = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0;
    op = OP_MULT; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_ok", 32'(ok), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LATENCY, 0, 0);
    run_op(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LATENCY, 0, 0);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LATENCY, 0, 0);
    run_op(OP_MULT,  32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000, MUL_LATENCY, 0, 0);
    run_op(OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, MUL_LATENCY, 0, 0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LATENCY, 0, 0);
    run_op(OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, DIV_LATENCY, 0, 0);
    run_op(OP_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, DIV_LATENCY, 0, 0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LATENCY, 0, 0);
    run_op(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LATENCY, 0, 0);
    run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_LATENCY, 0, 3);

    // Flush a divide mid-flight; no result may appear and hi/lo must hold.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    repeat (10) @(negedge clk);
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ok", 32'(ok), 32'd0);
    chk("flush_hi", hi, last_hi);
    chk("flush_lo", lo, last_lo);
    repeat (40) @(negedge clk);
    run_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, MUL_LATENCY, 0, 0);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd5000; b = 32'd7;
    repeat (6) @(negedge clk);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_ok", 32'(ok), 32'd0);
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    repeat (40) @(negedge clk);

    // Back-to-back: start stays high across DONE; ok pulses must be 4 cycles apart.
    run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LATENCY, 1, 0);
    first_ok = ok_cyc;
    run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, MUL_LATENCY, 0, 0);
    chk("b2b_ok_spacing", 32'(ok_cyc - first_ok), 32'd4);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/multdiv_engine.md
MULTDIV_ENGINE -- requirements
Module: multdiv_engine

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  execute-stage mult/div request, level, held until ok observed.
REQ-004 SHALL have ports: op  in  2  multicycle_t (MULT, MULTU, DIV, DIVU), valid while start.
REQ-005 SHALL have ports: a  in  32  operand rs; b  in  32  operand rt.
REQ-006 SHALL have ports: stall  in  1  execute stage held by another hazard; freezes DONE.
REQ-007 SHALL have ports: flush  in  1  abort in-flight op.
REQ-008 SHALL have ports: hi  out  32  result high/remainder; lo  out  32  result low/quotient.
REQ-009 SHALL have ports: ok  out  1  result valid for current request.

Function
REQ-010 SHALL implement FSM states IDLE, MUL1, MUL2, DIV, FIX, DONE.
REQ-011 IDLE: start=1 -> latch a, b, op; MULT/MULTU -> MUL1, DIV/DIVU -> DIV (iteration counter=0); start=0 -> stay.
REQ-012 MUL1: form four 16x16 unsigned partial products of operand magnitudes, register them -> MUL2.
REQ-013 MUL2: sum partial products to 64-bit product, negate if MULT and sign(a)^sign(b) -> DONE; multiply latency start->ok = 3 cycles.
REQ-014 DIV: one restoring radix-2 step per cycle on 32-bit magnitudes; after 32nd step -> FIX.
REQ-015 FIX: DIV quotient negated if sign(a)^sign(b), remainder takes sign of a; DIVU unchanged -> DONE; divide latency start->ok = 34 cycles.
REQ-016 b=0: quotient 0xFFFFFFFF, remainder = a (signed and unsigned), same latency, no exception.
REQ-017 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
REQ-018 hi/lo SHALL be registered, updated only on entry to DONE, held otherwise until next result.
REQ-019 ok = (state==DONE), no combinational path from start.
REQ-020 DONE: stall=1 -> stay (ok held 1); stall=0 -> IDLE next cycle (ok exactly one unstalled cycle).
REQ-021 start sampled only in IDLE; op/a/b changes while busy ignored.
REQ-022 Back-to-back requests: start high in the cycle after DONE is treated as new request from IDLE (one idle cycle between ops).
REQ-023 flush=1 in any state -> IDLE next cycle, hi/lo unchanged, ok=0 next cycle; flush has priority over start, stall.

Reset
REQ-024 reset SHALL force state=IDLE, counter=0, hi=0, lo=0, ok=0 next edge; reset mid-operation discards op, hi/lo=0.
REQ-025 reset SHALL take priority over flush, start, stall.

Structure
REQ-026 multicycle_t enum and MUL_LATENCY=3, DIV_LATENCY=34 constants SHALL live in shared package common.
REQ-027 FSM state enum SHALL be local to the module.
REQ-028 Divider datapath SHALL be one sub-module div_iter (one restoring step per enable, 32-bit magnitude, counter, done flag).

Verification
REQ-029 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> ok on cycle 3, hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 MULT a=0xFFFFFFFE(-2), b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, 3-cycle latency.
REQ-031 DIV a=0xFFFFFFF9(-7), b=2 -> ok on cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
REQ-032 DIVU 100/7 with stall=1 three cycles at DONE -> ok high 4 cycles, lo=14, hi=2 stable, then IDLE.
REQ-033 DIV started, flush at cycle 10 -> IDLE, ok=0, hi/lo retain prior values; new MULTU 3*5 completes lo=15.
REQ-034 reset asserted mid-DIV -> next cycle IDLE, hi=lo=0, ok=0; back-to-back MULTU pair yields 1 idle cycle between oks.
